// File: rtl/map_overlay_cached.sv
// map_overlay_cached: debug map overlay drawn from a one-row cell buffer that is refilled
// over a req/gnt map ROM port during hblank whenever the next line enters a new map row.
module map_overlay_cached #(
    parameter int MAP_WBITS = 4,
    parameter int MAP_HBITS = 4,
    parameter int MAP_SCALE = 3,
    parameter int H_VIEW    = 640,
    parameter int V_TOTAL   = 525
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_enable,
    input  logic [9:0]                     hpos,
    input  logic [9:0]                     vpos,
    input  logic [MAP_WBITS+MAP_SCALE-1:0] i_player_x,
    input  logic [MAP_HBITS+MAP_SCALE-1:0] i_player_y,
    output logic                           o_map_req,
    input  logic                           i_map_gnt,
    output logic [MAP_WBITS-1:0]           o_map_col,
    output logic [MAP_HBITS-1:0]           o_map_row,
    input  logic [1:0]                     i_map_val,
    output logic                           in_map_overlay,
    output logic [5:0]                     map_rgb
);
    localparam int MAP_W = 1 << MAP_WBITS;
    localparam int OV_W  = (1 << (MAP_WBITS + MAP_SCALE)) + 1;
    localparam int OV_H  = (1 << (MAP_HBITS + MAP_SCALE)) + 1;

    typedef enum logic {IDLE, FETCH} state_t;
    state_t state;

    logic [1:0]           cells [MAP_W];
    logic [MAP_W-1:0]     valid;
    logic [MAP_HBITS:0]   tag;
    logic                 tag_ok;
    logic [9:0]           nv;
    logic [MAP_HBITS:0]   nr;
    logic                 trigger;
    logic                 write;

    // nr is one bit wider than a row index so the closing gridline line (row 1<<MAP_HBITS) gets its own tag
    assign nv      = (vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1;
    assign nr      = nv[MAP_HBITS+MAP_SCALE:MAP_SCALE];
    assign trigger = i_enable && hpos == 10'(H_VIEW) && nv < 10'(OV_H) && (!tag_ok || nr != tag);
    assign write   = state == FETCH && i_map_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            o_map_req <= 1'b0;
            o_map_col <= '0;
            o_map_row <= '0;
            valid     <= '0;
            tag       <= '0;
            tag_ok    <= 1'b0;
        end else if (state == IDLE) begin
            if (trigger) begin
                state     <= FETCH;
                o_map_req <= 1'b1;
                o_map_col <= '0;
                o_map_row <= nr[MAP_HBITS-1:0];
                valid     <= '0;
                tag       <= nr;
                tag_ok    <= 1'b1;
            end
        end else if (i_map_gnt) begin
            valid[o_map_col] <= 1'b1;
            o_map_col        <= o_map_col + 1'b1;
            if (o_map_col == MAP_WBITS'(MAP_W - 1)) begin
                state     <= IDLE;
                o_map_req <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (write)
            cells[o_map_col] <= i_map_val;
    end

    logic [MAP_WBITS:0]   cx;
    logic [MAP_HBITS:0]   cy;
    logic [MAP_SCALE-1:0] px, py;
    logic                 in_ov, p_cell, p_pix, grid, cell_ok;
    logic [1:0]           cval;
    logic [5:0]           wall_rgb, rgb;

    // The buffer is read from registered state, so a same-cycle write shows up one cycle later
    always_comb begin
        cx       = hpos[MAP_WBITS+MAP_SCALE:MAP_SCALE];
        cy       = vpos[MAP_HBITS+MAP_SCALE:MAP_SCALE];
        px       = hpos[MAP_SCALE-1:0];
        py       = vpos[MAP_SCALE-1:0];
        in_ov    = i_enable && hpos < 10'(OV_W) && vpos < 10'(OV_H);
        p_cell   = cx == {1'b0, i_player_x[MAP_WBITS+MAP_SCALE-1:MAP_SCALE]} &&
                   cy == {1'b0, i_player_y[MAP_HBITS+MAP_SCALE-1:MAP_SCALE]};
        p_pix    = p_cell && px == i_player_x[MAP_SCALE-1:0] && py == i_player_y[MAP_SCALE-1:0];
        grid     = px == '0 || py == '0;
        cval     = cells[cx[MAP_WBITS-1:0]];
        cell_ok  = valid[cx[MAP_WBITS-1:0]] && tag_ok && tag == cy;
        wall_rgb = cval == 2'd1 ? 6'b11_10_00 :
                   cval == 2'd2 ? 6'b11_00_00 :
                   cval == 2'd3 ? 6'b11_00_10 : 6'b00_00_00;
        rgb      = p_pix    ? 6'b00_11_11 :
                   p_cell   ? 6'b00_01_00 :
                   grid     ? 6'b01_00_00 :
                   !cell_ok ? 6'b00_00_00 : wall_rgb;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_map_overlay <= 1'b0;
            map_rgb        <= '0;
        end else begin
            in_map_overlay <= in_ov;
            map_rgb        <= in_ov ? rgb : 6'b0;
        end
    end
endmodule
